magcomp_sort_ctrl: RTL
======================

# magcomp_sort_ctrl

Sequencing controller that owns one external magnitude comparator (`a`, `b` → `lt`, `gt`, `eq`). It sorts a burst of DEPTH unsigned words into ascending order. Words are loaded over a valid/ready input stream and sorted in place by bubble sort, one compare-and-swap per cycle through the shared comparator. The sorted words are then drained over a valid/ready output stream. The block sits between a sample source and the existing `magcomp` instance, which it drives combinationally each cycle.

## Interface
Parameters:
- `WIDTH`, 2, word width in bits; must match the comparator operand width.
- `DEPTH`, 4, words per burst; minimum 2.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `in_valid`  in  1  input word present.
- `in_ready`  out  1  block accepts an input word.
- `in_data`  in  WIDTH  input word.
- `out_valid`  out  1  sorted word present.
- `out_ready`  in  1  sink accepts the sorted word.
- `out_data`  out  WIDTH  sorted word.
- `busy`  out  1  high in SORT or DRAIN.
- `cmp_a`  out  WIDTH  comparator operand a.
- `cmp_b`  out  WIDTH  comparator operand b.
- `cmp_lt`, `cmp_gt`, `cmp_eq`  in  1 each  comparator results; combinational, valid in the same cycle.
- `cmp_err`  out  1  sticky flag; set when the comparator output is not one-hot during SORT.

## Operation
- Storage is `mem[0..DEPTH-1]`, WIDTH bits each.
- Counters:
  - `wr_idx` and `rd_idx`, range 0..DEPTH-1.
  - Pass counter `p`, range 0..DEPTH-2.
  - Compare index `i`, range 0..DEPTH-2-p.
- States are LOAD, SORT and DRAIN. Reset state is LOAD.
- LOAD:
  - `in_ready`=1.
  - On each `in_valid & in_ready` edge: `mem[wr_idx]<=in_data`, then `wr_idx` increments.
  - On the handshake with `wr_idx==DEPTH-1`: go to SORT with `wr_idx`=0, `p`=0, `i`=0.
- SORT:
  - `cmp_a=mem[i]`, `cmp_b=mem[i+1]`.
  - If `cmp_gt`, swap `mem[i]` and `mem[i+1]` at the edge. If `cmp_lt` or `cmp_eq`, no swap, so the sort is stable.
  - Only `cmp_gt` controls the swap.
  - If `i==DEPTH-2-p`: set `i`=0 and increment `p`. Otherwise increment `i`.
  - After the compare with `p==DEPTH-2`: go to DRAIN with `rd_idx`=0.
- DRAIN:
  - `out_valid`=1, `out_data=mem[rd_idx]`.
  - On each `out_valid & out_ready` edge, `rd_idx` increments.
  - On the handshake with `rd_idx==DEPTH-1`: go to LOAD with `rd_idx`=0.
- Outside SORT, `cmp_a` and `cmp_b` are driven to 0.
- `in_ready`=0 in SORT and DRAIN. `in_valid` is ignored in those states and no data is captured.
- `cmp_err`:
  - Set at the edge of any SORT cycle where `{cmp_lt,cmp_gt,cmp_eq}` is not exactly one-hot.
  - Cleared only by reset.
- `busy` = (state != LOAD).
- Arithmetic: all compares are unsigned. Counter widths are `$clog2(DEPTH)`, minimum 1. No counter wraps beyond its stated range.

## Timing
- Reset values, applied asynchronously while `rst_n`=0:
  - state=LOAD, all counters 0, all `mem` words 0.
  - `in_ready`=1, `out_valid`=0, `out_data`=0, `busy`=0.
  - `cmp_a`=`cmp_b`=0, `cmp_err`=0.
- Reset asserted mid-LOAD, mid-SORT or mid-DRAIN aborts the burst and discards all partial data. The first accept after release is `mem[0]`.
- The SORT phase lasts exactly DEPTH*(DEPTH-1)/2 cycles (6 for DEPTH=4), independent of data.
- `out_valid` rises on the cycle immediately after the last SORT cycle. For DEPTH=4 that is 7 cycles after the edge that accepted the last input.
- Backpressure: while `out_valid & !out_ready`, `out_data` and `rd_idx` hold stable.
- Back-to-back bursts: the final DRAIN handshake edge enters LOAD, and `in_ready`=1 in the next cycle. There is no overlap between drain and load.
- Minimum burst period for DEPTH=4 with no stalls: 4 load + 6 sort + 4 drain = 14 cycles.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles with random `in_valid`/`in_data` → `in_ready`=1, `out_valid`=0, `busy`=0, `cmp_a`=`cmp_b`=0, `cmp_err`=0. The first burst after release sorts correctly.
- Basic sort: load 3,1,2,0 with `out_ready`=1 and a real `magcomp` attached → exactly 6 SORT cycles, `out_valid` high 7 cycles after the last accept, outputs 0,1,2,3 on consecutive cycles, then `in_ready`=1.
- Duplicates and order: load 2,2,1,2 → outputs 1,2,2,2. Load 0,1,2,3 → 0,1,2,3 with no swaps; checked by `mem` staying unchanged on every cycle where `cmp_eq` or `cmp_lt` is high.
- Backpressure and ignored input: during DRAIN toggle `out_ready` 1,0,0,1,… and drive `in_valid`=1 throughout → `out_data` stable while stalled, `in_ready`=0, no data corruption, and the next burst loads cleanly.
- Reset mid-SORT: load 3,2,1,0, pulse `rst_n` low at the 3rd SORT cycle, then load 1,3,0,2 → outputs 0,1,2,3 and no residue from the first burst.
- Comparator fault: the bench model forces `cmp_lt`=`cmp_gt`=1 on one compare → that compare swaps, `cmp_err`=1 from the next cycle and stays 1 through later bursts until `rst_n` is asserted.

Source files
------------

// File: rtl/magcomp_sort_ctrl.sv
// magcomp_sort_ctrl: loads a burst of DEPTH words, bubble-sorts them in place
// through one shared external magnitude comparator (one compare-and-swap per
// cycle), then drains the sorted burst over a valid/ready stream.
module magcomp_sort_ctrl #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy,
  output logic [WIDTH-1:0] cmp_a,
  output logic [WIDTH-1:0] cmp_b,
  input  logic             cmp_lt,
  input  logic             cmp_gt,
  input  logic             cmp_eq,
  output logic             cmp_err
);

  localparam int CW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] LAST_IDX  = CW'(DEPTH - 1);
  localparam logic [CW-1:0] LAST_PASS = CW'(DEPTH - 2);

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SORT  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [CW-1:0]    wr_idx_reg, wr_idx_next;
  logic [CW-1:0]    rd_idx_reg, rd_idx_next;
  logic [CW-1:0]    p_reg, p_next;
  logic [CW-1:0]    i_reg, i_next;
  logic             err_reg, err_next;
  logic [WIDTH-1:0] mem_reg  [DEPTH];
  logic [WIDTH-1:0] mem_next [DEPTH];

  // Second operand index and the last compare index of the current pass;
  // both stay inside 0..DEPTH-1 because i never exceeds DEPTH-2-p.
  logic [CW-1:0] i_plus1;
  logic [CW-1:0] i_last;
  assign i_plus1 = i_reg + CW'(1);
  assign i_last  = LAST_PASS - p_reg;

  assign busy    = (state_reg != LOAD);
  assign cmp_err = err_reg;

  // Next-state, storage update and stream/comparator outputs
  always_comb begin
    state_next  = state_reg;
    wr_idx_next = wr_idx_reg;
    rd_idx_next = rd_idx_reg;
    p_next      = p_reg;
    i_next      = i_reg;
    err_next    = err_reg;
    for (int k = 0; k < DEPTH; k++) begin
      mem_next[k] = mem_reg[k];
    end
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    cmp_a     = '0;
    cmp_b     = '0;

    case (state_reg)
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          mem_next[wr_idx_reg] = in_data;
          if (wr_idx_reg == LAST_IDX) begin
            wr_idx_next = '0;
            p_next      = '0;
            i_next      = '0;
            state_next  = SORT;
          end else begin
            wr_idx_next = wr_idx_reg + CW'(1);
          end
        end
      end

      SORT: begin
        cmp_a = mem_reg[i_reg];
        cmp_b = mem_reg[i_plus1];
        if (!$onehot({cmp_lt, cmp_gt, cmp_eq})) begin
          err_next = 1'b1;
        end
        // Only a strict "greater" swaps, which keeps equal words in order.
        if (cmp_gt) begin
          mem_next[i_reg]   = mem_reg[i_plus1];
          mem_next[i_plus1] = mem_reg[i_reg];
        end
        if (i_reg == i_last) begin
          i_next = '0;
          if (p_reg == LAST_PASS) begin
            // Final compare: park the pass counter at 0 rather than
            // stepping it past its range.
            p_next      = '0;
            rd_idx_next = '0;
            state_next  = DRAIN;
          end else begin
            p_next = p_reg + CW'(1);
          end
        end else begin
          i_next = i_reg + CW'(1);
        end
      end

      DRAIN: begin
        out_valid = 1'b1;
        out_data  = mem_reg[rd_idx_reg];
        if (out_ready) begin
          if (rd_idx_reg == LAST_IDX) begin
            rd_idx_next = '0;
            state_next  = LOAD;
          end else begin
            rd_idx_next = rd_idx_reg + CW'(1);
          end
        end
      end

      default: begin
        state_next = LOAD;
      end
    endcase
  end

  // State, counters and sticky error flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= LOAD;
      wr_idx_reg <= '0;
      rd_idx_reg <= '0;
      p_reg      <= '0;
      i_reg      <= '0;
      err_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      wr_idx_reg <= wr_idx_next;
      rd_idx_reg <= rd_idx_next;
      p_reg      <= p_next;
      i_reg      <= i_next;
      err_reg    <= err_next;
    end
  end

  // Word storage; cleared on reset so an aborted burst leaves no residue
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        mem_reg[k] <= '0;
      end
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        mem_reg[k] <= mem_next[k];
      end
    end
  end

endmodule
